// File: rtl/cpu8_datapath.sv
// Bus-oriented 8-bit datapath for the accumulator CPU: PC, ACC, ALU, MAR/MDR,
// 256x8 RAM, B/C/temp/IR/output registers, all sharing one 8-bit bus.
module cpu8_datapath (
  input  logic       clk,
  input  logic       clear,
  input  logic       count_pc,
  input  logic       clear_pc,
  input  logic       load_pc,
  input  logic       enable_pc,
  input  logic       load_accum,
  input  logic       enable_accum,
  input  logic       load_mar,
  input  logic       ce_ram,
  input  logic       we_ram,
  input  logic       flip_flop,
  input  logic       load_mdr_reg,
  input  logic       enable_mdr_reg,
  input  logic       sub_mode,
  input  logic       enable_alu,
  input  logic       load_b_reg,
  input  logic       enable_b_reg,
  input  logic       load_c_reg,
  input  logic       enable_c_reg,
  input  logic       load_temp_reg,
  input  logic       load_output_reg,
  input  logic       load_inst_reg,
  input  logic       enable_inst_reg,
  input  logic       clear_inst_reg,
  input  logic       enable_input,
  input  logic [7:0] data_in,
  output logic [7:0] bus,
  output logic [7:0] data_out,
  output logic       zero_flag,
  output logic       carry_flag
);

  logic [7:0] pc;
  logic [7:0] accum;
  logic [7:0] mar;
  logic [7:0] mdr;
  logic [7:0] b_reg;
  logic [7:0] c_reg;
  logic [7:0] temp;
  logic [7:0] inst_reg;
  logic [7:0] ram [0:255];
  logic [7:0] ram_rdata;
  logic [7:0] mdr_input;
  logic [7:0] alu_operand;
  logic [8:0] alu_sum;
  logic [7:0] alu_result;
  logic       alu_carry;

  // Subtract is A + ~T + 1, so carry out means "no borrow".
  assign alu_operand = sub_mode ? ~temp : temp;
  assign alu_sum     = {1'b0, accum} + {1'b0, alu_operand} + {8'h00, sub_mode};
  assign alu_result  = alu_sum[7:0];
  assign alu_carry   = alu_sum[8];

  assign ram_rdata = ce_ram ? ram[mar] : 8'h00;
  assign mdr_input = flip_flop ? bus : ram_rdata;

  always_comb begin
    bus = 8'h00;
    if (enable_input)         bus = data_in;
    else if (enable_pc)       bus = pc;
    else if (enable_accum)    bus = accum;
    else if (enable_alu)      bus = alu_result;
    else if (enable_mdr_reg)  bus = mdr;
    else if (enable_b_reg)    bus = b_reg;
    else if (enable_c_reg)    bus = c_reg;
    else if (enable_inst_reg) bus = inst_reg;
  end

  always_ff @(posedge clk) begin
    if (clear)         pc <= 8'h00;
    else if (clear_pc) pc <= 8'h00;
    else if (load_pc)  pc <= bus;
    else if (count_pc) pc <= pc + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (clear)           accum <= 8'h00;
    else if (load_accum) accum <= bus;
  end

  always_ff @(posedge clk) begin
    if (clear)         mar <= 8'h00;
    else if (load_mar) mar <= bus;
  end

  always_ff @(posedge clk) begin
    if (clear)             mdr <= 8'h00;
    else if (load_mdr_reg) mdr <= mdr_input;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      b_reg <= 8'h00;
      c_reg <= 8'h00;
    end else begin
      if (load_b_reg) b_reg <= bus;
      if (load_c_reg) c_reg <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (clear)              temp <= 8'h00;
    else if (load_temp_reg) temp <= bus;
  end

  always_ff @(posedge clk) begin
    if (clear)                data_out <= 8'h00;
    else if (load_output_reg) data_out <= bus;
  end

  always_ff @(posedge clk) begin
    if (clear)               inst_reg <= 8'h00;
    else if (clear_inst_reg) inst_reg <= 8'h00;
    else if (load_inst_reg)  inst_reg <= bus;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (enable_alu) begin
      zero_flag  <= (alu_result == 8'h00);
      carry_flag <= alu_carry;
    end
  end

  // RAM has no reset; the write uses MAR/MDR as they stand before the edge.
  always_ff @(posedge clk) begin
    if (ce_ram && we_ram) ram[mar] <= mdr;
  end

endmodule

// File: tb/tb_cpu8_datapath.sv
// Scoreboarded bench for cpu8_datapath: directed plan sequences plus random
// strobe patterns, checked against an arithmetic reference model.
module tb_cpu8_datapath;

  typedef struct packed {
    logic count_pc, clear_pc, load_pc, enable_pc;
    logic load_accum, enable_accum, load_mar, ce_ram;
    logic we_ram, flip_flop, load_mdr_reg, enable_mdr_reg;
    logic sub_mode, enable_alu, load_b_reg, enable_b_reg;
    logic load_c_reg, enable_c_reg, load_temp_reg, load_output_reg;
    logic load_inst_reg, enable_inst_reg, clear_inst_reg, enable_input;
  } ctl_t;

  typedef struct {
    int         tag;
    logic [7:0] bus, out;
    logic       z, cy;
    bit         lb;
    logic [7:0] vb;
    bit         ls;
    logic [7:0] vo;
    logic       vz, vc;
  } exp_t;

  logic       clk;
  logic       clear;
  ctl_t       ctl;
  logic [7:0] data_in;
  logic [7:0] bus, data_out;
  logic       zero_flag, carry_flag;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  logic [7:0] m_pc, m_acc, m_mar, m_mdr, m_b, m_c, m_t, m_out, m_ir;
  logic       m_z, m_cy;
  logic [7:0] m_ram [256];

  cpu8_datapath dut (
    .clk(clk), .clear(clear),
    .count_pc(ctl.count_pc), .clear_pc(ctl.clear_pc), .load_pc(ctl.load_pc),
    .enable_pc(ctl.enable_pc), .load_accum(ctl.load_accum),
    .enable_accum(ctl.enable_accum), .load_mar(ctl.load_mar),
    .ce_ram(ctl.ce_ram), .we_ram(ctl.we_ram), .flip_flop(ctl.flip_flop),
    .load_mdr_reg(ctl.load_mdr_reg), .enable_mdr_reg(ctl.enable_mdr_reg),
    .sub_mode(ctl.sub_mode), .enable_alu(ctl.enable_alu),
    .load_b_reg(ctl.load_b_reg), .enable_b_reg(ctl.enable_b_reg),
    .load_c_reg(ctl.load_c_reg), .enable_c_reg(ctl.enable_c_reg),
    .load_temp_reg(ctl.load_temp_reg), .load_output_reg(ctl.load_output_reg),
    .load_inst_reg(ctl.load_inst_reg), .enable_inst_reg(ctl.enable_inst_reg),
    .clear_inst_reg(ctl.clear_inst_reg), .enable_input(ctl.enable_input),
    .data_in(data_in), .bus(bus), .data_out(data_out),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (bus !== e.bus) begin
        miscompares++;
        $display("FAIL model_bus tag=%0d t=%0t got %02h want %02h", e.tag, $time, bus, e.bus);
      end
      if (data_out !== e.out) begin
        miscompares++;
        $display("FAIL model_data_out tag=%0d t=%0t got %02h want %02h", e.tag, $time, data_out, e.out);
      end
      if (zero_flag !== e.z || carry_flag !== e.cy) begin
        miscompares++;
        $display("FAIL model_flags tag=%0d t=%0t got z=%b c=%b want z=%b c=%b",
                 e.tag, $time, zero_flag, carry_flag, e.z, e.cy);
      end
      if (e.lb && bus !== e.vb) begin
        miscompares++;
        $display("FAIL plan_bus tag=%0d got %02h want %02h", e.tag, bus, e.vb);
      end
      if (e.ls && (data_out !== e.vo || zero_flag !== e.vz || carry_flag !== e.vc)) begin
        miscompares++;
        $display("FAIL plan_state tag=%0d got out=%02h z=%b c=%b want out=%02h z=%b c=%b",
                 e.tag, data_out, zero_flag, carry_flag, e.vo, e.vz, e.vc);
      end
    end
  end

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_mar = 0; m_mdr = 0; m_b = 0; m_c = 0;
    m_t = 0; m_out = 0; m_ir = 0; m_z = 0; m_cy = 0;
  endtask

  // Drive one cycle, push what the model says should be seen, advance the model.
  task automatic step(input ctl_t c, input logic [7:0] din, input int tag = 0,
                      input bit lb = 0, input logic [7:0] vb = 8'h00,
                      input bit ls = 0, input logic [7:0] vo = 8'h00,
                      input logic vz = 1'b0, input logic vc = 1'b0);
    exp_t       x;
    logic [7:0] mb, res, rd, mdr_in;
    logic       co;
    int         s;
    ctl = c;
    data_in = din;
    if (c.sub_mode) begin
      res = m_acc - m_t;
      co  = (m_acc >= m_t);
    end else begin
      s   = int'(m_acc) + int'(m_t);
      res = 8'(s % 256);
      co  = (s > 255);
    end
    if (c.enable_input)         mb = din;
    else if (c.enable_pc)       mb = m_pc;
    else if (c.enable_accum)    mb = m_acc;
    else if (c.enable_alu)      mb = res;
    else if (c.enable_mdr_reg)  mb = m_mdr;
    else if (c.enable_b_reg)    mb = m_b;
    else if (c.enable_c_reg)    mb = m_c;
    else if (c.enable_inst_reg) mb = m_ir;
    else                        mb = 8'h00;
    rd     = c.ce_ram ? m_ram[m_mar] : 8'h00;
    mdr_in = c.flip_flop ? mb : rd;
    x.tag = tag; x.bus = mb; x.out = m_out; x.z = m_z; x.cy = m_cy;
    x.lb = lb; x.vb = vb; x.ls = ls; x.vo = vo; x.vz = vz; x.vc = vc;
    exp_q.push_back(x);
    if (c.ce_ram && c.we_ram) m_ram[m_mar] = m_mdr;
    if (c.clear_pc)      m_pc = 8'h00;
    else if (c.load_pc)  m_pc = mb;
    else if (c.count_pc) m_pc = m_pc + 8'h01;
    if (c.load_accum)      m_acc = mb;
    if (c.load_mar)        m_mar = mb;
    if (c.load_mdr_reg)    m_mdr = mdr_in;
    if (c.load_b_reg)      m_b = mb;
    if (c.load_c_reg)      m_c = mb;
    if (c.load_temp_reg)   m_t = mb;
    if (c.load_output_reg) m_out = mb;
    if (c.clear_inst_reg)     m_ir = 8'h00;
    else if (c.load_inst_reg) m_ir = mb;
    if (c.enable_alu) begin
      m_z  = (res == 8'h00);
      m_cy = co;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic in_to(input logic [7:0] din, input int which);
    ctl_t c;
    c = '0;
    c.enable_input = 1'b1;
    case (which)
      0: c.load_accum = 1'b1;
      1: c.load_temp_reg = 1'b1;
      2: c.load_mar = 1'b1;
      3: c.load_pc = 1'b1;
      default: c.load_b_reg = 1'b1;
    endcase
    step(c, din);
  endtask

  task automatic alu_case(input logic [7:0] a, input logic [7:0] t, input logic sub,
                          input int tag, input logic [7:0] r, input logic z, input logic cy);
    ctl_t c;
    in_to(a, 0);
    in_to(t, 1);
    c = '0; c.enable_alu = 1'b1; c.sub_mode = sub; c.load_output_reg = 1'b1;
    step(c, 8'h00, tag, 1, r);
    c = '0;
    step(c, 8'h00, tag + 1, 0, 8'h00, 1, r, z, cy);
  endtask

  initial begin
    ctl_t c;
    ctl = '0;
    data_in = 8'h00;
    clear = 1'b1;
    for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();

    // reset state
    c = '0; step(c, 8'h00, 1, 1, 8'h00, 1, 8'h00, 1'b0, 1'b0);
    c = '0; c.enable_pc = 1'b1; step(c, 8'h00, 2, 1, 8'h00);

    // RAM has no reset: clear every location through MDR (=00 after clear)
    for (int a = 0; a < 256; a++) begin
      in_to(8'(a), 2);
      c = '0; c.ce_ram = 1'b1; c.we_ram = 1'b1; step(c, 8'h00);
    end

    // preload RAM[01]=5A, then read it back through MDR
    in_to(8'h01, 2);
    c = '0; c.enable_input = 1'b1; c.flip_flop = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'h5A);
    c = '0; c.ce_ram = 1'b1; c.we_ram = 1'b1; step(c, 8'h00);
    c = '0; c.flip_flop = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'h00);
    in_to(8'h01, 2);
    c = '0; c.ce_ram = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'h00);
    c = '0; c.enable_mdr_reg = 1'b1; step(c, 8'h00, 3, 1, 8'h5A);

    // ALU cases
    alu_case(8'h0A, 8'h05, 1'b0, 10, 8'h0F, 1'b0, 1'b0);
    alu_case(8'h05, 8'h05, 1'b1, 12, 8'h00, 1'b1, 1'b1);
    alu_case(8'h03, 8'h05, 1'b1, 14, 8'hFE, 1'b0, 1'b0);
    alu_case(8'hFF, 8'h01, 1'b0, 16, 8'h00, 1'b1, 1'b1);

    // RAM write of A5 at 20
    in_to(8'h20, 2);
    c = '0; c.enable_input = 1'b1; c.flip_flop = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'hA5);
    c = '0; c.ce_ram = 1'b1; c.we_ram = 1'b1; step(c, 8'h00);
    c = '0; c.flip_flop = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'h00);
    c = '0; c.ce_ram = 1'b1; c.load_mdr_reg = 1'b1; step(c, 8'h00);
    c = '0; c.enable_mdr_reg = 1'b1; step(c, 8'h00, 20, 1, 8'hA5);

    // PC load, wrap, clear priority
    in_to(8'hFE, 3);
    c = '0; c.enable_pc = 1'b1; c.count_pc = 1'b1; step(c, 8'h00, 30, 1, 8'hFE);
    c = '0; c.enable_pc = 1'b1; c.count_pc = 1'b1; step(c, 8'h00, 31, 1, 8'hFF);
    c = '0; c.enable_pc = 1'b1; step(c, 8'h00, 32, 1, 8'h00);
    c = '0; c.count_pc = 1'b1; step(c, 8'h00);
    c = '0; c.enable_pc = 1'b1; c.count_pc = 1'b1; c.clear_pc = 1'b1; step(c, 8'h00, 33, 1, 8'h01);
    c = '0; c.enable_pc = 1'b1; step(c, 8'h00, 34, 1, 8'h00);

    // bus priority
    in_to(8'h77, 4);
    c = '0; c.enable_input = 1'b1; c.enable_b_reg = 1'b1; step(c, 8'h3C, 40, 1, 8'h3C);
    c = '0; c.enable_b_reg = 1'b1; step(c, 8'h00, 41, 1, 8'h77);

    // random strobe patterns, each strobe high about a quarter of the time
    for (int i = 0; i < 3000; i++) begin
      c = ctl_t'($urandom & $urandom);
      if ($urandom_range(0, 3) != 0) c.clear_pc = 1'b0;
      step(c, 8'($urandom), 1000 + i);
    end

    c = '0;
    ctl = c;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
